// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide engine.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;
    localparam int unsigned ITER_COUNT   = 32;
    localparam int unsigned CNT_W        = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between decode, muldiv_unit and the LO/HI register block.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, lo_out, hi_out, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, lo_out, hi_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; doubles as abs() when neg_i is the sign bit.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing {hi, lo} with a done strobe.
// Signed MULT/DIV are enabled by defining MULDIV_SIGNED_EN; otherwise they act as MULTU/DIVU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, a_raw_q, lo_q, hi_q;
    logic             sign_a_q, sign_b_q, b_zero_q;
    logic             busy_q, done_q, dbz_q;

    logic             signed_op_c, neg_a_c, neg_b_c, is_div_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c, quot_fix_c, rem_fix_c;
    logic [DW-1:0]    prod_fix_c;
    logic [WIDTH:0]   mul_sum_c, div_rem_c, div_trial_c;

`ifdef MULDIV_SIGNED_EN
    assign signed_op_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`else
    assign signed_op_c = 1'b0;
`endif

    assign neg_a_c  = signed_op_c & bus.a[WIDTH-1];
    assign neg_b_c  = signed_op_c & bus.b[WIDTH-1];
    assign is_div_c = op_is_div(op_q);

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.neg_i(neg_a_c), .val_i(bus.a), .res_o(abs_a_c));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.neg_i(neg_b_c), .val_i(bus.b), .res_o(abs_b_c));

    muldiv_signfix #(.W(DW)) u_fix_prod (
        .neg_i ((sign_a_q ^ sign_b_q) & ~is_div_c),
        .val_i (acc_q),
        .res_o (prod_fix_c)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_quot (
        .neg_i ((sign_a_q ^ sign_b_q) & is_div_c),
        .val_i (acc_q[WIDTH-1:0]),
        .res_o (quot_fix_c)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .neg_i (sign_a_q & is_div_c),
        .val_i (acc_q[DW-1:WIDTH]),
        .res_o (rem_fix_c)
    );

    // One iteration: multiply adds into the upper half then shifts right;
    // divide shifts left and keeps the trial difference when it is non-negative.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
        div_rem_c   = acc_q[DW-1:WIDTH-1];
        div_trial_c = div_rem_c - {1'b0, opnd_q};
        acc_d       = acc_q;
        if (is_div_c) begin
            if (!div_trial_c[WIDTH]) begin
                acc_d = {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[DW-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[DW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q  <= S_CALC;
                        op_q     <= op_e'(bus.op);
                        cnt_q    <= '0;
                        a_raw_q  <= bus.a;
                        sign_a_q <= neg_a_c;
                        sign_b_q <= neg_b_c;
                        b_zero_q <= (bus.b == '0);
                        busy_q   <= 1'b1;
                        if (op_is_div(bus.op)) begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_a_c};
                            opnd_q <= abs_b_c;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_b_c};
                            opnd_q <= abs_a_c;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (!is_div_c) begin
                        lo_q <= prod_fix_c[WIDTH-1:0];
                        hi_q <= prod_fix_c[DW-1:WIDTH];
                    end else if (b_zero_q) begin
                        lo_q  <= '1;
                        hi_q  <= a_raw_q;
                        dbz_q <= 1'b1;
                    end else begin
                        lo_q <= quot_fix_c;
                        hi_q <= rem_fix_c;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.lo_out      = lo_q;
    assign bus.hi_out      = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random vs. arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
        bit          sgn;
        longint      sa, sb, sp;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        sgn = (op == 2'b00) || (op == 2'b10);
`else
        sgn = 1'b0;
`endif
        dbz = 1'b0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!op[1]) begin
            if (sgn) begin
                sp = sa * sb;
                up = 64'(sp);
            end else begin
                up = {32'b0, a} * {32'b0, b};
            end
            lo = up[31:0];
            hi = up[63:32];
        end else if (b == 32'd0) begin
            lo  = 32'hFFFF_FFFF;
            hi  = a;
            dbz = 1'b1;
        end else if (sgn) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // Call at a negedge; returns at the negedge of the first CALC cycle.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Samples at negedges until done; returns at the negedge of the done cycle.
    task automatic wait_done(output logic [31:0] lo, output logic [31:0] hi, output logic dbz,
                             output int busy_cnt);
        int n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 80) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(bus.done), 64'd1);
        check("busy_low_at_done", 64'(bus.busy), 64'd0);
        lo  = bus.lo_out;
        hi  = bus.hi_out;
        dbz = bus.div_by_zero;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                                 input logic edbz, input bit chk_busy);
        logic [31:0] lo, hi;
        logic        dbz;
        int          bc;
        start_op(op, a, b);
        wait_done(lo, hi, dbz, bc);
        check({tag, "_lo"}, 64'(lo), 64'(elo));
        check({tag, "_hi"}, 64'(hi), 64'(ehi));
        check({tag, "_dbz"}, 64'(dbz), 64'(edbz));
        if (chk_busy) check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] elo, ehi, lo, hi;
        logic        edbz, dbz;
        int          bc, dcount;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[4] = '{2'b11, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
        vecs[6] = '{2'b10, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1};
        vecs[7] = '{2'b01, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0};
        vecs[9] = '{2'b11, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
`ifdef MULDIV_SIGNED_EN
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
`else
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'h0000_0006, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'h0000_0001, 1'b0};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst_lo", 64'(bus.lo_out), 64'd0);
        check("rst_hi", 64'(bus.hi_out), 64'd0);
        @(negedge clk);

        // Directed table; each start lands in the previous op's done cycle.
        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].lo, vecs[i].hi, vecs[i].dbz, 1'b1);
        end

        // done is a single-cycle pulse; flag clears and results hold afterwards.
        @(negedge clk);
        check("done_width", 64'(bus.done), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        run_and_check("dbz_seq", 2'b11, 32'h0000_00AB, 32'd0, 32'hFFFF_FFFF, 32'h0000_00AB, 1'b1, 1'b1);
        @(negedge clk);
        check("dbz_clear", 64'(bus.div_by_zero), 64'd0);
        check("hold_lo", 64'(bus.lo_out), 64'hFFFF_FFFF);
        check("hold_hi", 64'(bus.hi_out), 64'h0000_00AB);

        // start during CALC is ignored and not queued.
        start_op(2'b01, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        start_op(2'b11, 32'd1000, 32'd10);
        wait_done(lo, hi, dbz, bc);
        check("ign_lo", 64'(lo), 64'd15);
        check("ign_hi", 64'(hi), 64'd0);
        @(negedge clk);
        check("ign_not_queued", 64'(bus.busy), 64'd0);

        // Reset mid-operation aborts with no done pulse.
        start_op(2'b11, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_lo", 64'(bus.lo_out), 64'd0);
        check("abort_hi", 64'(bus.hi_out), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        run_and_check("after_abort", 2'b01, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 1'b1);

        // Random operations against the arithmetic model, with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            ref_model(op, a, b, elo, ehi, edbz);
            run_and_check($sformatf("rnd%0d", i), op, a, b, elo, ehi, edbz, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
